// File: rtl/mem_pkg.sv
// Shared types and constants for the flash fetch controller and its formatter.
package mem_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 10;

    localparam logic [1:0] LOAD_SIZE_BYTE = 2'd0;
    localparam logic [1:0] LOAD_SIZE_HALF = 2'd1;
    localparam logic [1:0] LOAD_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_RELEASE = 2'd2
    } fetch_state_e;

    // Everything latched from the winning port when a request is accepted.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic              is_unsigned;
        logic              is_load;
    } fetch_req_t;

    // SPI delivers the lowest-addressed byte first, in [31:24].
    function automatic logic [DATA_W-1:0] bswap32(input logic [DATA_W-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Turns a big-endian flash word into a little-endian instruction word and a
// size-selected, sign/zero-extended load result.
module load_formatter
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] raw,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] load_data
);

    always_comb begin
        word      = bswap32(raw);
        load_data = word;
        case (size)
            LOAD_SIZE_BYTE: load_data = {{24{~is_unsigned & word[7]}},  word[7:0]};
            LOAD_SIZE_HALF: load_data = {{16{~is_unsigned & word[15]}}, word[15:0]};
            default:        load_data = word;
        endcase
    end

endmodule

// File: rtl/mem_fetch_ctrl.sv
// Arbitrates instruction/data requests onto the SPI flash reader, formats the
// returned word and aborts reads that never complete.
module mem_fetch_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              fetch_err,
    output logic [ADDR_W-1:0] mem_target_address,
    output logic              mem_start_fetch,
    input  logic              mem_fetch_done,
    input  logic [DATA_W-1:0] mem_fetched_data
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_e      state, state_nxt;
    fetch_req_t        req_q;
    logic [CNT_W-1:0]  cnt;
    logic              accept_load, accept_instr;
    logic              fetch_ok, fetch_to;
    logic [DATA_W-1:0] fmt_word, fmt_load;

    // Data port wins when both requests are up in the same IDLE cycle.
    assign accept_load  = (state == ST_IDLE) && load_req;
    assign accept_instr = (state == ST_IDLE) && !load_req && instr_req;
    assign fetch_ok     = (state == ST_FETCH) && mem_fetch_done;
    assign fetch_to     = (state == ST_FETCH) && !mem_fetch_done && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (load_req || instr_req) state_nxt = ST_FETCH;
            ST_FETCH:   if (fetch_ok || fetch_to)  state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Start is a pure decode of state so an async reset drops it at once.
    always_comb begin
        mem_start_fetch = (state == ST_FETCH);
    end

    assign mem_target_address = req_q.addr;

    load_formatter u_fmt (
        .raw         (mem_fetched_data),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .word        (fmt_word),
        .load_data   (fmt_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            cnt         <= '0;
            instr_valid <= 1'b0;
            load_valid  <= 1'b0;
            fetch_err   <= 1'b0;
            instr_data  <= '0;
            load_data   <= '0;
        end else begin
            instr_valid <= 1'b0;
            load_valid  <= 1'b0;
            fetch_err   <= 1'b0;
            if (accept_load) begin
                req_q <= '{addr: load_addr, size: load_size,
                           is_unsigned: load_unsigned, is_load: 1'b1};
                cnt   <= '0;
            end else if (accept_instr) begin
                req_q <= '{addr: instr_addr, size: LOAD_SIZE_WORD,
                           is_unsigned: 1'b0, is_load: 1'b0};
                cnt   <= '0;
            end
            if (state == ST_FETCH) cnt <= cnt + 1'b1;
            // A timed-out transfer still completes its port, with zero data.
            if (fetch_ok || fetch_to) begin
                fetch_err <= fetch_to;
                if (req_q.is_load) begin
                    load_valid <= 1'b1;
                    load_data  <= fetch_ok ? fmt_load : '0;
                end else begin
                    instr_valid <= 1'b1;
                    instr_data  <= fetch_ok ? fmt_word : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// Self-checking bench: vector table, arbitration/timeout/reset sequences and
// randomized transfers against a byte-arithmetic reference model.
module tb_mem_fetch_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        instr_req = 1'b0;
    logic [23:0] instr_addr = '0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        load_req = 1'b0;
    logic [23:0] load_addr = '0;
    logic [1:0]  load_size = '0;
    logic        load_unsigned = 1'b0;
    logic        load_valid;
    logic [31:0] load_data;
    logic        fetch_err;
    logic [23:0] mem_target_address;
    logic        mem_start_fetch;
    logic        mem_fetch_done;
    logic [31:0] mem_fetched_data;

    // second instance with a short timeout
    logic        t_load_req = 1'b0;
    logic [23:0] t_load_addr = '0;
    logic        t_instr_valid, t_load_valid, t_fetch_err, t_start;
    logic [31:0] t_instr_data, t_load_data;
    logic [23:0] t_target;
    logic        t_done = 1'b0;
    logic [31:0] t_fdata = '0;

    mem_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .load_req(load_req), .load_addr(load_addr), .load_size(load_size),
        .load_unsigned(load_unsigned), .load_valid(load_valid), .load_data(load_data),
        .fetch_err(fetch_err), .mem_target_address(mem_target_address),
        .mem_start_fetch(mem_start_fetch), .mem_fetch_done(mem_fetch_done),
        .mem_fetched_data(mem_fetched_data)
    );

    mem_fetch_ctrl #(.TIMEOUT_CYCLES(16)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .instr_req(1'b0), .instr_addr(24'h0),
        .instr_valid(t_instr_valid), .instr_data(t_instr_data),
        .load_req(t_load_req), .load_addr(t_load_addr), .load_size(2'd2),
        .load_unsigned(1'b0), .load_valid(t_load_valid), .load_data(t_load_data),
        .fetch_err(t_fetch_err), .mem_target_address(t_target),
        .mem_start_fetch(t_start), .mem_fetch_done(t_done),
        .mem_fetched_data(t_fdata)
    );

    // Flash reader model: done (held) after flash_lat cycles of start; <0 = never.
    int          flash_lat = 10;
    logic [31:0] flash_word = '0;
    int          wait_cnt;
    logic [23:0] seen_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_fetch_done   <= 1'b0;
            mem_fetched_data <= '0;
            wait_cnt         <= 0;
            seen_addr        <= '0;
        end else if (!mem_start_fetch) begin
            mem_fetch_done <= 1'b0;
            wait_cnt       <= 0;
        end else begin
            if (wait_cnt == 0) seen_addr <= mem_target_address;
            wait_cnt <= wait_cnt + 1;
            if (flash_lat >= 0 && wait_cnt + 1 >= flash_lat) begin
                mem_fetch_done   <= 1'b1;
                mem_fetched_data <= flash_word;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: memory bytes in address order, little-endian assembly.
    function automatic logic [31:0] model(input bit is_load, input logic [31:0] raw,
                                          input logic [1:0] sz, input bit uns);
        longint b[4];
        longint v;
        for (int i = 0; i < 4; i++) b[i] = longint'((raw >> (24 - 8 * i)) & 32'hFF);
        v = b[0] + b[1] * 256 + b[2] * 65536 + b[3] * 16777216;
        if (is_load && sz == 2'd0) begin
            v = b[0];
            if (!uns && v >= 128) v = v - 256;
        end else if (is_load && sz == 2'd1) begin
            v = b[0] + b[1] * 256;
            if (!uns && v >= 32768) v = v - 65536;
        end
        return 32'(v);
    endfunction

    logic [31:0] last_instr = '0;
    logic [31:0] last_load = '0;

    task automatic run_one(input bit is_load, input logic [23:0] a, input logic [1:0] sz,
                           input bit uns, input logic [31:0] raw, input int lat,
                           input logic [31:0] exp, input string tag);
        bit ok;
        logic [31:0] d;
        logic err, st;
        flash_word = raw;
        flash_lat  = lat;
        @(posedge clk); #1;
        if (is_load) begin
            load_req = 1'b1; load_addr = a; load_size = sz; load_unsigned = uns;
        end else begin
            instr_req = 1'b1; instr_addr = a;
        end
        ok = 0; d = '0; err = 1'b0; st = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (is_load ? load_valid : instr_valid) begin
                ok  = 1;
                d   = is_load ? load_data : instr_data;
                err = fetch_err;
                st  = mem_start_fetch;
            end
        end
        @(posedge clk); #1;
        load_req = 1'b0; instr_req = 1'b0;
        check({tag, "_valid_seen"}, 32'(ok), 32'd1);
        check({tag, "_data"}, d, exp);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_addr"}, 32'(seen_addr), 32'(a));
        check({tag, "_start_low_at_valid"}, 32'(st), 32'd0);
        if (is_load) begin
            check({tag, "_instr_hold"}, instr_data, last_instr);
            last_load = exp;
        end else begin
            check({tag, "_load_hold"}, load_data, last_load);
            last_instr = exp;
        end
    endtask

    task automatic to_xfer(input logic [23:0] a, output int nf, output bit ok,
                           output logic [31:0] d, output logic err);
        @(posedge clk); #1;
        t_load_addr = a; t_load_req = 1'b1;
        nf = 0; ok = 0; d = '0; err = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (t_load_valid) begin
                ok = 1; d = t_load_data; err = t_fetch_err;
            end else if (t_start) nf++;
        end
        @(posedge clk); #1;
        t_load_req = 1'b0;
    endtask

    typedef struct {
        bit          is_load;
        logic [23:0] addr;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] raw;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int nf, tl, ti, low, gap;
        bit ok, ovl;
        logic [31:0] d, a_r, r_raw;
        logic err;
        bit r_load, r_uns;
        logic [1:0] r_sz;
        int r_lat;

        vecs[0] = '{0, 24'h000100, 2'd2, 0, 32'h13050000, 80, 32'h00000513};
        vecs[1] = '{1, 24'h000200, 2'd0, 0, 32'h80123456, 3,  32'hFFFFFF80};
        vecs[2] = '{1, 24'h000201, 2'd0, 1, 32'h80123456, 3,  32'h00000080};
        vecs[3] = '{1, 24'h000302, 2'd1, 0, 32'h34F2ABCD, 5,  32'hFFFFF234};
        vecs[4] = '{1, 24'h000303, 2'd1, 1, 32'h34F2ABCD, 5,  32'h0000F234};
        vecs[5] = '{1, 24'h123456, 2'd2, 0, 32'h11223344, 1,  32'h44332211};
        vecs[6] = '{1, 24'hFFFFFF, 2'd3, 0, 32'hDEADBEEF, 7,  32'hEFBEADDE};
        vecs[7] = '{1, 24'h000010, 2'd0, 0, 32'h7F000000, 0,  32'h0000007F};
        vecs[8] = '{0, 24'h000003, 2'd2, 0, 32'hAABBCCDD, 2,  32'hDDCCBBAA};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_load_valid", 32'(load_valid), 0);
        check("rst_fetch_err", 32'(fetch_err), 0);
        check("rst_start", 32'(mem_start_fetch), 0);
        check("rst_addr", 32'(mem_target_address), 0);
        check("rst_instr_data", instr_data, 0);
        check("rst_load_data", load_data, 0);
        check("rst_to_start", 32'(t_start), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_one(vecs[i].is_load, vecs[i].addr, vecs[i].sz, vecs[i].uns,
                    vecs[i].raw, vecs[i].lat, vecs[i].exp, $sformatf("vec%0d", i));

        // both ports request together: load first, then instruction
        flash_word = 32'h80000000; flash_lat = 5;
        @(posedge clk); #1;
        load_req = 1'b1; load_addr = 24'h000AA0; load_size = 2'd0; load_unsigned = 1'b0;
        instr_req = 1'b1; instr_addr = 24'h000BB0;
        tl = -1; ti = -1; low = 0; gap = -1; ovl = 0;
        for (int c = 0; c < 500 && ti < 0; c++) begin
            @(negedge clk);
            if (load_valid && instr_valid) ovl = 1;
            if (load_valid && tl < 0) tl = c;
            if (instr_valid) ti = c;
            if (mem_start_fetch) begin
                if (tl >= 0 && gap < 0) gap = low;
            end else if (tl >= 0 && gap < 0) low++;
            @(posedge clk); #1;
            if (tl == c) load_req = 1'b0;
            if (ti == c) instr_req = 1'b0;
        end
        load_req = 1'b0; instr_req = 1'b0;
        check("arb_load_seen", 32'(tl >= 0), 1);
        check("arb_load_first", 32'(ti > tl), 1);
        check("arb_no_overlap", 32'(ovl), 0);
        check("arb_start_gap", 32'(gap), 2);
        check("arb_load_data", load_data, 32'hFFFFFF80);
        check("arb_instr_data", instr_data, 32'h00000080);
        check("arb_instr_addr", 32'(seen_addr), 32'h000BB0);
        last_load = 32'hFFFFFF80; last_instr = 32'h00000080;

        for (int i = 0; i < 24; i++) begin
            r_load = 1'($urandom_range(0, 1));
            a_r    = $urandom;
            r_sz   = 2'($urandom_range(0, 3));
            r_uns  = 1'($urandom_range(0, 1));
            r_raw  = $urandom;
            r_lat  = int'($urandom_range(0, 30));
            run_one(r_load, a_r[23:0], r_sz, r_uns, r_raw, r_lat,
                    model(r_load, r_raw, r_sz, r_uns), $sformatf("rnd%0d", i));
        end

        // short-timeout instance: a good load, then two timeouts
        t_done = 1'b1; t_fdata = 32'h11223344;
        to_xfer(24'h000040, nf, ok, d, err);
        check("to_pre_valid", 32'(ok), 1);
        check("to_pre_data", d, 32'h44332211);
        check("to_pre_cycles", 32'(nf), 1);
        t_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            to_xfer(24'h000080, nf, ok, d, err);
            check($sformatf("to%0d_valid", k), 32'(ok), 1);
            check($sformatf("to%0d_err", k), 32'(err), 1);
            check($sformatf("to%0d_data", k), d, 0);
            check($sformatf("to%0d_fetch_cycles", k), 32'(nf), 16);
            check($sformatf("to%0d_addr", k), 32'(t_target), 32'h000080);
            @(negedge clk);
            check($sformatf("to%0d_err_pulse", k), 32'(t_fetch_err), 0);
            check($sformatf("to%0d_idle_start", k), 32'(t_start), 0);
        end

        // async reset in the middle of a hung read
        flash_lat = -1;
        @(posedge clk); #1;
        load_req = 1'b1; load_addr = 24'h000555; load_size = 2'd2;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (mem_start_fetch) ok = 1;
        end
        check("rstmid_started", 32'(ok), 1);
        repeat (39) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_start", 32'(mem_start_fetch), 0);
        check("rstmid_load_valid", 32'(load_valid), 0);
        check("rstmid_instr_valid", 32'(instr_valid), 0);
        check("rstmid_err", 32'(fetch_err), 0);
        load_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_load = '0; last_instr = '0;
        run_one(1, 24'h000556, 2'd1, 1, 32'hCDAB0000, 4, 32'h0000ABCD, "post_rst_load");
        run_one(0, 24'h000600, 2'd2, 0, 32'h13050000, 6, 32'h00000513, "post_rst_instr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_fetch_ctrl.md
Name: mem_fetch_ctrl

Overview:
- Sits between the CPU core and the SPI flash reader (`mem_read`).
- Arbitrates between the instruction-fetch port and the data-load port, and sequences the `start_fetch`/`fetch_done` handshake.
- Converts the big-endian SPI byte stream into little-endian RV32E words, with byte/half extraction and sign/zero extension.
- Provides a timeout watchdog so a hung flash read cannot stall the core forever.

Parameters:
- TIMEOUT_CYCLES, 1023: clk cycles in FETCH without `mem_fetch_done` before the request is aborted. Range 1..1023; counter is 10 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset; resets all state immediately on assertion
- instr_req  in  1  instruction fetch request; held high until instr_valid
- instr_addr  in  24  byte address of instruction word
- instr_valid  out  1  one-cycle pulse: instr_data valid
- instr_data  out  32  little-endian instruction word
- load_req  in  1  data load request; held high until load_valid
- load_addr  in  24  byte address of load
- load_size  in  2  0=byte, 1=half, 2=word, 3=treated as word
- load_unsigned  in  1  1=zero-extend, 0=sign-extend (byte/half only)
- load_valid  out  1  one-cycle pulse: load_data valid
- load_data  out  32  extended load result
- fetch_err  out  1  one-cycle pulse alongside a valid pulse that was caused by timeout
- mem_target_address  out  24  to `mem_read` target_address
- mem_start_fetch  out  1  to `mem_read` start_fetch
- mem_fetch_done  in  1  from `mem_read` fetch_done
- mem_fetched_data  in  32  from `mem_read` fetched_data; first SPI byte in [31:24]

Behaviour:
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - latched address, size, unsigned flag, port select and timeout counter all 0
- States: IDLE, FETCH, RELEASE.
- IDLE:
  - If load_req=1: accept the data port, latching load_addr, load_size and load_unsigned. The data port has priority when both requests are high.
  - Else if instr_req=1: accept the instruction port, latching instr_addr.
  - On accept: next cycle is FETCH, with mem_start_fetch=1, mem_target_address = latched address, and counter cleared.
- FETCH:
  - mem_start_fetch stays 1; mem_target_address stays stable.
  - Counter increments every cycle.
  - On mem_fetch_done=1: register the formatted result, pulse the selected port's valid for exactly one cycle (the first RELEASE cycle), and go to RELEASE.
  - If the counter reaches TIMEOUT_CYCLES first: go to RELEASE, pulse the selected valid with data 0 and pulse fetch_err.
- RELEASE:
  - Exactly one cycle; mem_start_fetch=0 so `mem_read` returns to its start state.
  - Next state is IDLE, which may accept a new request on that same cycle's following edge.
- Data outputs hold their last value between valid pulses.
  - instr_data/load_data change only when their own port completes.
- Byte formatting: b0=data[31:24], b1=[23:16], b2=[15:8], b3=[7:0]; word = {b3,b2,b1,b0}.
  - instr_data = word.
  - load byte: {24{ext},b0}.
  - load half: {16{ext},b1,b0}.
  - load word / size 3: word.
  - ext = load_unsigned ? 0 : MSB of the extracted field.
  - No alignment restriction: flash reads start at any byte address.
- Request protocol:
  - Requests are sampled only in IDLE.
  - The requestor may drop req, or present a new address with req held, on the edge after seeing valid.
  - A req asserted or dropped during FETCH/RELEASE has no effect on the in-flight transfer.
- Reset mid-operation: mem_start_fetch drops to 0 immediately (async), which aborts `mem_read`; no valid pulse is produced.
- mem_fetch_done arriving in IDLE or RELEASE is ignored.

Decomposition:
- Shared package `mem_pkg`:
  - FSM state encoding.
  - LOAD_SIZE_BYTE/HALF/WORD constants.
  - ADDR_W=24, DATA_W=32.
- One natural sub-module: `load_formatter`. It is combinational and does the byte swap, size select and extension. It is instantiated once and fed by the latched size/unsigned flags.

Test Plan:
- Instruction fetch: instr_req, addr 0x000100; model returns 0x13050000 after 80 cycles.
  - Required: mem_target_address=0x000100; instr_valid pulse with instr_data=0x00000513; mem_start_fetch low for exactly 1 cycle after.
- Signed byte load: load_size=0, load_unsigned=0, model data 0x80xxxxxx.
  - Required: load_data=0xFFFFFF80.
  - Repeat with load_unsigned=1: load_data=0x00000080.
- Half load: load_size=1, signed, model data 0x34F2xxxx.
  - Required: load_data=0xFFFFF234.
- Simultaneous instr_req and load_req in IDLE: load is served first, then the instruction.
  - Required: load_valid precedes instr_valid; no overlapping mem_start_fetch.
- Timeout: TIMEOUT_CYCLES=16, model never asserts done.
  - Required: after 16 FETCH cycles, load_valid=1, fetch_err=1 and load_data=0 in the same cycle; FSM returns to IDLE.
- Reset mid-FETCH: assert rst_n=0 at cycle 40 of a transfer.
  - Required: mem_start_fetch=0 and all valids=0 without waiting for a clock edge; a subsequent request completes normally.
